commit_trace_drain: RTL and testbench

//  Consumer end of the commit-record interface: takes the per-cycle multi-issue commit bundle
//  (valid mask, PC, RF write, exception) and buffers it in a bundle FIFO.

---
 rtl/commit_trace_drain_pkg.sv | 12 +
 rtl/commit_trace_fifo.sv | 34 +++
 rtl/commit_trace_drain.sv | 118 +++++++++++
 tb/tb_commit_trace_drain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_drain_pkg.sv
// commit_trace_drain_pkg: shared widths, serializer state encoding and bundle/record width helpers
package commit_trace_drain_pkg;
  localparam int PC_W = 30;
  localparam int NCPU_REG_AW = 5;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  function automatic int trc_rec_w(int dw);
    return 1 + PC_W + 1 + NCPU_REG_AW + dw;
  endfunction
  function automatic int trc_bundle_w(int iw, int dw);
    return 33 + iw * trc_rec_w(dw);
  endfunction
endpackage

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: sync FIFO; i_push/i_wdata in, i_pop, o_rdata head, o_rdata_nxt second entry, o_full/o_empty/o_count
module commit_trace_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [DW-1:0] o_rdata_nxt,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  logic [DW-1:0] r_mem [1<<AW];
  logic [AW:0] r_wr, r_rd, w_rd_inc;
  logic w_we, w_re;
  assign o_full = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign o_empty = r_wr == r_rd;
  assign o_count = r_wr - r_rd;
  assign w_we = i_push & ~o_full;
  assign w_re = i_pop & ~o_empty;
  assign w_rd_inc = r_rd + (AW+1)'(1);
  assign o_rdata = r_mem[r_rd[AW-1:0]];
  assign o_rdata_nxt = r_mem[w_rd_inc[AW-1:0]];
  always_ff @(posedge clk) begin
    r_wr <= rst ? '0 : w_we ? r_wr + (AW+1)'(1) : r_wr;
    r_rd <= rst ? '0 : w_re ? w_rd_inc : r_rd;
  end
  always_ff @(posedge clk)
    if (w_we) r_mem[r_wr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/commit_trace_drain.sv
// commit_trace_drain: buffers cmt_* commit bundles in a FIFO (cmt_stall_req/ovf_sticky) and serializes them to the trc_valid/trc_ready record stream
module commit_trace_drain
  import commit_trace_drain_pkg::*;
#(
  parameter int CONFIG_DW = 64,
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_P_DEPTH = 2,
  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IW-1:0]                   cmt_valid,
  input  logic [PC_W*IW-1:0]              cmt_pc,
  input  logic [IW-1:0]                   cmt_rf_we,
  input  logic [NCPU_REG_AW*IW-1:0]       cmt_rf_waddr,
  input  logic [CONFIG_DW*IW-1:0]         cmt_rf_wdat,
  input  logic                            cmt_excp,
  input  logic [31:0]                     cmt_excp_vect,
  output logic                            cmt_stall_req,
  output logic                            trc_valid,
  input  logic                            trc_ready,
  output logic [15:0]                     trc_seq,
  output logic [CONFIG_P_ISSUE_WIDTH-1:0] trc_slot,
  output logic [PC_W-1:0]                 trc_pc,
  output logic                            trc_rf_we,
  output logic [NCPU_REG_AW-1:0]          trc_rf_waddr,
  output logic [CONFIG_DW-1:0]            trc_rf_wdat,
  output logic                            trc_excp,
  output logic [31:0]                     trc_excp_vect,
  output logic                            ovf_sticky
);
  localparam int DEPTH = 1 << CONFIG_P_DEPTH;
  localparam int TRC_BUNDLE_W = trc_bundle_w(IW, CONFIG_DW);
  localparam int CW = CONFIG_P_DEPTH + 1;
  typedef struct packed {
    logic                              excp;
    logic [31:0]                       vect;
    logic [IW-1:0]                     valid;
    logic [IW-1:0][PC_W-1:0]           pc;
    logic [IW-1:0]                     we;
    logic [IW-1:0][NCPU_REG_AW-1:0]    waddr;
    logic [IW-1:0][CONFIG_DW-1:0]      wdat;
  } bundle_t;
  bundle_t w_in, w_head, w_head_nxt, r_bundle, w_bundle_nxt;
  state_t r_state, w_state_nxt;
  logic [IW-1:0] r_mask, w_mask_nxt, w_onehot;
  logic [CW-1:0] w_count, w_cnt_nxt;
  logic [CONFIG_P_ISSUE_WIDTH-1:0] w_slot;
  logic [15:0] r_seq;
  logic w_full, w_empty, w_push, w_push_ok, w_fire, w_last, w_pop, r_stall, r_ovf;
  assign w_in = {cmt_excp, cmt_excp_vect, cmt_valid, cmt_pc, cmt_rf_we, cmt_rf_waddr, cmt_rf_wdat};
  commit_trace_fifo #(.DW(TRC_BUNDLE_W), .AW(CONFIG_P_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push_ok),
    .i_pop      (w_pop),
    .i_wdata    (w_in),
    .o_rdata    (w_head),
    .o_rdata_nxt(w_head_nxt),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );
  assign w_push = |cmt_valid;
  assign w_push_ok = w_push & ~w_full;
  assign w_fire = (r_state == SEND) & trc_ready;
  assign w_onehot = IW'(1) << w_slot;
  assign w_last = (r_mask & ~w_onehot) == '0;
  assign w_cnt_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);
  always_comb begin
    w_slot = '0;
    for (int k = IW - 1; k >= 0; k--)
      if (r_mask[k]) w_slot = CONFIG_P_ISSUE_WIDTH'(k);
  end
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt = r_mask;
    w_bundle_nxt = r_bundle;
    w_pop = 1'b0;
    if (r_state == IDLE) begin
      if (!w_empty) begin
        w_state_nxt = SEND;
        w_bundle_nxt = w_head;
        w_mask_nxt = w_head.valid;
      end
    end else if (trc_ready) begin
      w_mask_nxt = r_mask & ~w_onehot;
      if (w_last) begin
        w_pop = 1'b1;
        if (w_count > CW'(1)) begin
          w_bundle_nxt = w_head_nxt;
          w_mask_nxt = w_head_nxt.valid;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_state_nxt;
    r_mask <= rst ? '0 : w_mask_nxt;
    r_bundle <= rst ? '0 : w_bundle_nxt;
    r_seq <= rst ? '0 : w_fire ? r_seq + 16'd1 : r_seq;
    r_stall <= rst ? 1'b0 : w_cnt_nxt > CW'(DEPTH - 2);
    r_ovf <= rst ? 1'b0 : r_ovf | (w_push & w_full);
  end
  assign trc_valid = r_state == SEND;
  assign trc_seq = r_seq;
  assign trc_slot = trc_valid ? w_slot : '0;
  assign trc_pc = trc_valid ? r_bundle.pc[w_slot] : '0;
  assign trc_rf_we = trc_valid & r_bundle.we[w_slot];
  assign trc_rf_waddr = trc_valid ? r_bundle.waddr[w_slot] : '0;
  assign trc_rf_wdat = trc_valid ? r_bundle.wdat[w_slot] : '0;
  assign trc_excp = trc_valid & r_bundle.excp & (r_mask == r_bundle.valid);
  assign trc_excp_vect = trc_excp ? r_bundle.vect : '0;
  assign cmt_stall_req = r_stall;
  assign ovf_sticky = r_ovf;
endmodule

// File: tb/tb_commit_trace_drain.sv
// tb_commit_trace_drain: directed self-checking bench for commit_trace_drain (IW=2, DEPTH=4)
module tb_commit_trace_drain;
  logic clk = 1'b0, rst;
  logic [1:0] cmt_valid, cmt_rf_we;
  logic [59:0] cmt_pc;
  logic [9:0] cmt_rf_waddr;
  logic [127:0] cmt_rf_wdat;
  logic cmt_excp, cmt_stall_req, trc_valid, trc_ready, trc_rf_we, trc_excp, ovf_sticky;
  logic [31:0] cmt_excp_vect, trc_excp_vect;
  logic [15:0] trc_seq;
  logic [0:0] trc_slot;
  logic [29:0] trc_pc;
  logic [4:0] trc_rf_waddr;
  logic [63:0] trc_rf_wdat;
  int n_cmp = 0, n_err = 0;
  logic [15:0] exp_seq;
  logic [29:0] exp_q[$];
  always #5 clk = ~clk;
  commit_trace_drain dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_rf_we(cmt_rf_we),
    .cmt_rf_waddr(cmt_rf_waddr), .cmt_rf_wdat(cmt_rf_wdat),
    .cmt_excp(cmt_excp), .cmt_excp_vect(cmt_excp_vect), .cmt_stall_req(cmt_stall_req),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_seq(trc_seq), .trc_slot(trc_slot),
    .trc_pc(trc_pc), .trc_rf_we(trc_rf_we), .trc_rf_waddr(trc_rf_waddr),
    .trc_rf_wdat(trc_rf_wdat), .trc_excp(trc_excp), .trc_excp_vect(trc_excp_vect),
    .ovf_sticky(ovf_sticky)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    cmt_valid = '0; cmt_pc = '0; cmt_rf_we = '0; cmt_rf_waddr = '0; cmt_rf_wdat = '0;
    cmt_excp = 1'b0; cmt_excp_vect = '0;
  endtask
  initial begin
    int pushed, acc, cyc, n;
    logic held;
    logic [29:0] h_pc, e_pc;
    logic [15:0] h_seq;
    rst = 1'b1; trc_ready = 1'b0; clear_in();
    step(); step();
    chk("rst_valid", trc_valid, 0);
    chk("rst_seq", trc_seq, 0);
    chk("rst_stall", cmt_stall_req, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_pc", trc_pc, 0);
    rst = 1'b0;
    cmt_valid = 2'b11; cmt_pc = {30'h104, 30'h100}; cmt_rf_we = 2'b01;
    cmt_rf_waddr = {5'd0, 5'd3}; cmt_rf_wdat = {64'h0, 64'hDEAD}; trc_ready = 1'b1;
    step(); clear_in(); #1;
    chk("t1_latency", trc_valid, 0);
    step();
    chk("t1_r0_valid", trc_valid, 1);
    chk("t1_r0_slot", trc_slot, 0);
    chk("t1_r0_pc", trc_pc, 30'h100);
    chk("t1_r0_seq", trc_seq, 0);
    chk("t1_r0_we", trc_rf_we, 1);
    chk("t1_r0_waddr", trc_rf_waddr, 3);
    chk("t1_r0_wdat", trc_rf_wdat, 64'hDEAD);
    step();
    chk("t1_r1_valid", trc_valid, 1);
    chk("t1_r1_slot", trc_slot, 1);
    chk("t1_r1_pc", trc_pc, 30'h104);
    chk("t1_r1_seq", trc_seq, 1);
    chk("t1_r1_we", trc_rf_we, 0);
    step();
    chk("t1_done", trc_valid, 0);
    cmt_valid = 2'b10; cmt_pc = {30'h208, 30'h0}; cmt_excp = 1'b1; cmt_excp_vect = 32'h80;
    step(); clear_in(); step();
    chk("t2_slot", trc_slot, 1);
    chk("t2_pc", trc_pc, 30'h208);
    chk("t2_excp", trc_excp, 1);
    chk("t2_vect", trc_excp_vect, 32'h80);
    chk("t2_seq", trc_seq, 2);
    step();
    chk("t2_done", trc_valid, 0);
    cmt_valid = 2'b11; cmt_pc = {30'h30C, 30'h308}; cmt_excp = 1'b1; cmt_excp_vect = 32'h44;
    step(); clear_in(); step();
    chk("t2b_s0_excp", trc_excp, 1);
    chk("t2b_s0_vect", trc_excp_vect, 32'h44);
    step();
    chk("t2b_s1_slot", trc_slot, 1);
    chk("t2b_s1_excp", trc_excp, 0);
    chk("t2b_s1_vect", trc_excp_vect, 0);
    step();
    exp_seq = 16'd5;
    trc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmt_valid = 2'b01; cmt_pc = {30'h0, 30'(32'h200 + i)};
      step();
      if (i == 1) chk("t3_stall_lo", cmt_stall_req, 0);
      if (i == 2) chk("t3_stall_hi", cmt_stall_req, 1);
      if (i == 3) chk("t3_ovf_lo", ovf_sticky, 0);
      if (i == 4) chk("t3_ovf_hi", ovf_sticky, 1);
    end
    clear_in(); trc_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", trc_valid, 1);
      chk("t3_drain_pc", trc_pc, 64'h200 + i);
      chk("t3_drain_seq", trc_seq, exp_seq);
      exp_seq++;
      step();
    end
    chk("t3_drain_done", trc_valid, 0);
    chk("t3_stall_clr", cmt_stall_req, 0);
    for (int c = 0; c < 10; c++) begin
      cmt_valid = (c < 8) ? 2'b01 : 2'b00; cmt_pc = {30'h0, 30'(32'h300 + c)};
      #1;
      if (c >= 2) begin
        chk("t4_valid", trc_valid, 1);
        chk("t4_pc", trc_pc, 64'h300 + c - 2);
        chk("t4_seq", trc_seq, exp_seq);
        exp_seq++;
      end
      step();
    end
    clear_in(); #1;
    chk("t4_done", trc_valid, 0);
    pushed = 0; acc = 0; held = 1'b0; h_pc = '0; h_seq = '0;
    for (int c = 0; c < 300 && acc < 12; c++) begin
      if (pushed < 6 && !cmt_stall_req) begin
        cmt_valid = 2'b11;
        cmt_pc = {30'(32'h401 + 2 * pushed), 30'(32'h400 + 2 * pushed)};
        exp_q.push_back(30'(32'h400 + 2 * pushed));
        exp_q.push_back(30'(32'h401 + 2 * pushed));
        pushed++;
      end else cmt_valid = 2'b00;
      trc_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        chk("t5_hold_valid", trc_valid, 1);
        chk("t5_hold_pc", trc_pc, h_pc);
        chk("t5_hold_seq", trc_seq, h_seq);
      end
      if (trc_valid && trc_ready) begin
        e_pc = exp_q.size() > 0 ? exp_q.pop_front() : 30'h3FFFFFFF;
        chk("t5_order_pc", trc_pc, e_pc);
        chk("t5_seq", trc_seq, exp_seq);
        exp_seq++; acc++; held = 1'b0;
      end else held = trc_valid;
      h_pc = trc_pc; h_seq = trc_seq;
      step();
    end
    chk("t5_count", acc, 12);
    clear_in(); trc_ready = 1'b1;
    step(); step();
    n = 16'hFFFF - exp_seq; pushed = 0; acc = 0; cyc = 0;
    while (acc < n && cyc < 70000) begin
      cmt_valid = (pushed < n && !cmt_stall_req) ? 2'b01 : 2'b00;
      cmt_pc = {30'h0, 30'(pushed)};
      if (cmt_valid != 0) pushed++;
      #1;
      if (trc_valid && trc_ready) acc++;
      step();
      cyc++;
    end
    chk("t6_pump", acc, n);
    clear_in(); trc_ready = 1'b0;
    cmt_valid = 2'b11; cmt_pc = {30'h504, 30'h500};
    step(); clear_in(); step();
    chk("t6_ffff_seq", trc_seq, 16'hFFFF);
    chk("t6_ffff_pc", trc_pc, 30'h500);
    step();
    chk("t6_hold_seq", trc_seq, 16'hFFFF);
    chk("t6_hold_pc", trc_pc, 30'h500);
    trc_ready = 1'b1; #1;
    step();
    chk("t6_wrap_seq", trc_seq, 0);
    chk("t6_wrap_slot", trc_slot, 1);
    chk("t6_wrap_pc", trc_pc, 30'h504);
    trc_ready = 1'b0;
    cmt_valid = 2'b01; cmt_pc = {30'h0, 30'h600};
    step(); clear_in();
    chk("t6_ovf_pre", ovf_sticky, 1);
    chk("t6_valid_pre", trc_valid, 1);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", trc_valid, 0);
    chk("t6_rst_ovf", ovf_sticky, 0);
    chk("t6_rst_seq", trc_seq, 0);
    chk("t6_rst_stall", cmt_stall_req, 0);
    rst = 1'b0; trc_ready = 1'b1;
    step(); step();
    chk("t6_fifo_empty", trc_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
